apb_master_bridge: RTL and testbench

- APB3/APB4 master bridge with a three-state IDLE/SETUP/ACCESS controller.
- Converts a simple local request interface into APB bus transfers toward up to SLAVES_NUM slaves.
- Upstream side: Transfer, ADDR_in, DATA_in, WRITE_in, SEL_in, STROB_in and PROT_in.
- Returns read data on DATA_out and the slave error on SLVERR_out.
- Sits between the system controller and APB peripherals (GPIO, UART).

---
 rtl/apb_master_bridge.sv | 127 ++++++++++++
 tb/tb_apb_master_bridge.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a local transfer request into an APB
// SETUP/ACCESS sequence toward one of SLAVES_NUM slaves. It returns read
// data and the slave error of the last completed transfer.
module apb_master_bridge #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STROBE_WIDTH = 4,
  parameter int SLAVES_NUM   = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    Transfer,
  input  logic [ADDR_WIDTH-1:0]   ADDR_in,
  input  logic [DATA_WIDTH-1:0]   DATA_in,
  input  logic                    WRITE_in,
  input  logic [SLAVES_NUM-1:0]   SEL_in,
  input  logic [STROBE_WIDTH-1:0] STROB_in,
  input  logic [2:0]              PROT_in,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  output logic [DATA_WIDTH-1:0]   DATA_out,
  output logic                    SLVERR_out,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [SLAVES_NUM-1:0]   PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [STROBE_WIDTH-1:0] PSTRB,
  output logic [2:0]              PPROT
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                  state, state_d;
  logic                    start;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [SLAVES_NUM-1:0]   psel_d;
  logic                    penable_d;
  logic                    pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_d;
  logic [STROBE_WIDTH-1:0] pstrb_d;
  logic [2:0]              pprot_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic                    slverr_d;

  // Next-state and next bus values. The registered bus outputs double as the
  // request latch, so they are loaded only when a new transfer is accepted.
  always_comb begin
    state_d   = state;
    start     = 1'b0;
    paddr_d   = PADDR;
    psel_d    = PSEL;
    penable_d = PENABLE;
    pwrite_d  = PWRITE;
    pwdata_d  = PWDATA;
    pstrb_d   = PSTRB;
    pprot_d   = PPROT;
    data_d    = DATA_out;
    slverr_d  = SLVERR_out;
    unique case (state)
      IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
        start     = Transfer && (|SEL_in);
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          slverr_d = PSLVERR;
          if (!PWRITE) data_d = PRDATA;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = IDLE;
          start     = Transfer && (|SEL_in);
        end
      end
      default: state_d = IDLE;
    endcase
    // Acceptance from IDLE and back-to-back acceptance at completion share one load path
    if (start) begin
      state_d   = SETUP;
      psel_d    = SEL_in;
      penable_d = 1'b0;
      paddr_d   = ADDR_in;
      pwrite_d  = WRITE_in;
      pprot_d   = PROT_in;
      pwdata_d  = WRITE_in ? DATA_in : '0;
      pstrb_d   = WRITE_in ? STROB_in : '0;
    end
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state      <= IDLE;
      PADDR      <= '0;
      PSEL       <= '0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      PSTRB      <= '0;
      PPROT      <= '0;
      DATA_out   <= '0;
      SLVERR_out <= 1'b0;
    end else begin
      state      <= state_d;
      PADDR      <= paddr_d;
      PSEL       <= psel_d;
      PENABLE    <= penable_d;
      PWRITE     <= pwrite_d;
      PWDATA     <= pwdata_d;
      PSTRB      <= pstrb_d;
      PPROT      <= pprot_d;
      DATA_out   <= data_d;
      SLVERR_out <= slverr_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: directed scenarios plus randomized
// transfers, checked by a scoreboard against a phase-level APB model.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        Transfer;
  logic [31:0] ADDR_in;
  logic [31:0] DATA_in;
  logic        WRITE_in;
  logic [1:0]  SEL_in;
  logic [3:0]  STROB_in;
  logic [2:0]  PROT_in;
  logic [31:0] PRDATA  = '0;
  logic        PREADY  = 1'b0;
  logic        PSLVERR = 1'b0;
  logic [31:0] DATA_out;
  logic        SLVERR_out;
  logic [31:0] PADDR;
  logic [1:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;

  apb_master_bridge #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .STROBE_WIDTH(4),
    .SLAVES_NUM  (2)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .Transfer  (Transfer),
    .ADDR_in   (ADDR_in),
    .DATA_in   (DATA_in),
    .WRITE_in  (WRITE_in),
    .SEL_in    (SEL_in),
    .STROB_in  (STROB_in),
    .PROT_in   (PROT_in),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .DATA_out  (DATA_out),
    .SLVERR_out(SLVERR_out),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PPROT     (PPROT)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sel;
    logic        write;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } pkt_t;

  typedef enum {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

  pkt_t        exp_q[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned acc_cnt = 0;

  // slave behaviour: manual values or random responses
  logic        slave_auto = 1'b0;
  logic        man_pready = 1'b1;
  logic [31:0] man_prdata = '0;
  logic        man_pslverr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave responses change 3 time units after each rising edge
  always @(posedge PCLK) begin
    #3;
    if (slave_auto) begin
      PREADY  = ($urandom % 3) != 0;
      PRDATA  = $urandom;
      PSLVERR = ($urandom % 4) == 0;
    end else begin
      PREADY  = man_pready;
      PRDATA  = man_prdata;
      PSLVERR = man_pslverr;
    end
  end

  // Reference model and monitor: the inputs seen here are those the DUT just sampled
  phase_t      m_phase = PH_IDLE;
  pkt_t        cur     = '0;
  logic [31:0] m_data  = '0;
  logic        m_err   = 1'b0;
  logic        bus_known = 1'b0;

  task automatic model_start();
    if (exp_q.size() == 0) begin
      chk("unexpected_start", 64'd1, 64'd0);
    end else begin
      cur = exp_q.pop_front();
      acc_cnt++;
      bus_known = 1'b1;
      m_phase = PH_SETUP;
    end
  endtask

  always @(posedge PCLK) begin
    #1;
    if (PRESETn) begin
      m_phase   = PH_IDLE;
      cur       = '0;
      m_data    = '0;
      m_err     = 1'b0;
      bus_known = 1'b1;
    end else begin
      case (m_phase)
        PH_IDLE:  if (Transfer && SEL_in != 2'b00) model_start();
        PH_SETUP: m_phase = PH_ACCESS;
        default: begin
          if (PREADY) begin
            m_err = PSLVERR;
            if (!cur.write) m_data = PRDATA;
            m_phase   = PH_IDLE;
            bus_known = 1'b0;
            if (Transfer && SEL_in != 2'b00) model_start();
          end
        end
      endcase
    end
    chk("penable", 64'(PENABLE), 64'(m_phase == PH_ACCESS));
    chk("psel", 64'(PSEL), (m_phase == PH_IDLE) ? 64'd0 : 64'(cur.sel));
    if (m_phase != PH_IDLE || bus_known) begin
      chk("paddr", 64'(PADDR), 64'(cur.addr));
      chk("pwrite", 64'(PWRITE), 64'(cur.write));
      chk("pwdata", 64'(PWDATA), 64'(cur.wdata));
      chk("pstrb", 64'(PSTRB), 64'(cur.strb));
      chk("pprot", 64'(PPROT), 64'(cur.prot));
    end
    chk("data_out", 64'(DATA_out), 64'(m_data));
    chk("slverr_out", 64'(SLVERR_out), 64'(m_err));
  end

  task automatic scramble();
    Transfer = 1'b0;
    ADDR_in  = $urandom;
    DATA_in  = $urandom;
    WRITE_in = 1'($urandom);
    SEL_in   = 2'($urandom);
    STROB_in = 4'($urandom);
    PROT_in  = 3'($urandom);
  endtask

  // Present one request and return just after the edge that accepted it
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [1:0] s, input logic [3:0] st, input logic [2:0] p);
    pkt_t        k;
    int unsigned c0;
    Transfer = 1'b1;
    ADDR_in  = a;
    DATA_in  = d;
    WRITE_in = w;
    SEL_in   = s;
    STROB_in = st;
    PROT_in  = p;
    k.addr  = a;
    k.sel   = s;
    k.write = w;
    k.wdata = w ? d : 32'd0;
    k.strb  = w ? st : 4'd0;
    k.prot  = p;
    exp_q.push_back(k);
    c0 = acc_cnt;
    for (int i = 0; i < 100 && acc_cnt == c0; i++) begin
      @(posedge PCLK); #2;
    end
    if (acc_cnt == c0) begin
      chk("accept_timeout", 64'd0, 64'd1);
      exp_q.delete();
    end
    scramble();
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge PCLK); #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn  = 1'b1;
    Transfer = 1'b1;
    ADDR_in  = 32'h55;
    DATA_in  = 32'h1234;
    WRITE_in = 1'b1;
    SEL_in   = 2'b10;
    STROB_in = 4'hF;
    PROT_in  = 3'd5;
    cycles(2);

    // release reset into a write, then a back-to-back read returning 500
    PRESETn = 1'b0;
    man_pready = 1'b1;
    issue(32'h0, 32'd1000, 1'b1, 2'b10, 4'd2, 3'd0);
    man_prdata = 32'd500;
    issue(32'h10, 32'hFFFF_FFFF, 1'b0, 2'b01, 4'hF, 3'd2);
    cycles(3);

    // read with three wait states
    man_pready = 1'b0;
    man_prdata = 32'h1234_5678;
    issue(32'h20, 32'h0, 1'b0, 2'b10, 4'hC, 3'd1);
    cycles(4);
    man_pready = 1'b1;
    cycles(3);

    // slave error on a read, then a clean write clears it
    man_pslverr = 1'b1;
    man_prdata  = 32'h0000_DEAD;
    issue(32'h30, 32'h0, 1'b0, 2'b01, 4'h3, 3'd7);
    cycles(2);
    man_pslverr = 1'b0;
    man_prdata  = 32'hAAAA_5555;
    issue(32'h34, 32'hCAFE_F00D, 1'b1, 2'b01, 4'h9, 3'd3);
    cycles(3);

    // request with no slave selected is ignored
    Transfer = 1'b1;
    SEL_in   = 2'b00;
    cycles(5);
    scramble();
    cycles(1);

    // randomized traffic with random slave timing
    slave_auto = 1'b1;
    for (int i = 0; i < 150; i++) begin
      issue($urandom, $urandom, 1'($urandom), ($urandom % 2) ? 2'b01 : 2'b10,
            4'($urandom), 3'($urandom));
      if (($urandom % 3) == 0) cycles($urandom_range(3, 1));
    end
    cycles(12);
    slave_auto = 1'b0;
    cycles(1);

    // reset in the middle of a stalled ACCESS
    man_pready = 1'b0;
    issue(32'h40, 32'h0, 1'b0, 2'b10, 4'hF, 3'd4);
    cycles(2);
    PRESETn = 1'b1;
    cycles(1);
    PRESETn = 1'b0;
    exp_q.delete();
    man_pready = 1'b1;
    cycles(4);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
